// File: rtl/dmem_arbiter_if.sv
// Bundles the core, ext and data-memory sides of the data-memory arbiter.
// The arbiter uses the slave modport; requesters and the memory use master.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  core_req;
  logic                  core_we;
  logic [DATA_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wd;
  logic [2:0]            core_funct3;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  stall_core;

  logic                  ext_req;
  logic                  ext_we;
  logic [DATA_WIDTH-1:0] ext_addr;
  logic [DATA_WIDTH-1:0] ext_wd;
  logic [2:0]            ext_funct3;
  logic                  ext_gnt;
  logic                  ext_rvalid;
  logic [DATA_WIDTH-1:0] ext_rdata;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [2:0]            mem_funct3;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport slave (
    input  core_req, core_we, core_addr, core_wd, core_funct3,
    output core_rdata, stall_core,
    input  ext_req, ext_we, ext_addr, ext_wd, ext_funct3,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_we, mem_addr, mem_wd, mem_funct3,
    input  mem_rd
  );

  modport master (
    output core_req, core_we, core_addr, core_wd, core_funct3,
    input  core_rdata, stall_core,
    output ext_req, ext_we, ext_addr, ext_wd, ext_funct3,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_we, mem_addr, mem_wd, mem_funct3,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core has priority, ext is force-granted
// after STARVE_LIMIT cycles of waiting behind a busy core.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Down-counter of cycles ext may still wait; terminal count forces a grant.
  logic [3:0]            starve_left;
  logic                  starve_tc;
  logic                  ext_gnt_c;
  logic                  ext_rd_gnt;
  logic                  ext_rvalid_q;
  logic [DATA_WIDTH-1:0] ext_rdata_q;

  assign starve_tc  = (starve_left == 4'd0);
  assign ext_gnt_c  = !rst && bus.ext_req && (!bus.core_req || starve_tc);
  assign ext_rd_gnt = ext_gnt_c && !bus.ext_we;

  always_comb begin
    bus.ext_gnt    = ext_gnt_c;
    bus.stall_core = bus.core_req && ext_gnt_c;
    bus.core_rdata = bus.mem_rd;
    bus.ext_rvalid = ext_rvalid_q;
    bus.ext_rdata  = ext_rdata_q;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = bus.core_addr;
    bus.mem_wd     = bus.core_wd;
    bus.mem_funct3 = bus.core_funct3;
    if (ext_gnt_c) begin
      bus.mem_we     = bus.ext_we;
      bus.mem_addr   = bus.ext_addr;
      bus.mem_wd     = bus.ext_wd;
      bus.mem_funct3 = bus.ext_funct3;
    end else if (!rst) begin
      bus.mem_we     = bus.core_req && bus.core_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_left  <= LIMIT;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      if (ext_gnt_c || !bus.ext_req)
        starve_left <= LIMIT;
      else if (bus.core_req && !starve_tc)
        starve_left <= starve_left - 4'd1;
      ext_rvalid_q <= ext_rd_gnt;
      if (ext_rd_gnt)
        ext_rdata_q <= bus.mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(32)) bus ();

  dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
  assign bus.mem_rd = mem[bus.mem_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic core_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd);
    bus.core_req    = req;
    bus.core_we     = we;
    bus.core_addr   = addr;
    bus.core_wd     = wd;
    bus.core_funct3 = 3'd2;
  endtask

  task automatic ext_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd);
    bus.ext_req    = req;
    bus.ext_we     = we;
    bus.ext_addr   = addr;
    bus.ext_wd     = wd;
    bus.ext_funct3 = 3'd2;
  endtask

  initial begin
    rst = 1'b1;
    core_drive(1'b1, 1'b1, 32'h0, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h4, 32'h0);
    #1;

    // reset with both requesters active
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt",    32'(bus.ext_gnt),    32'd0);
      chk("rst_stall",  32'(bus.stall_core), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we),     32'd0);
      if (i == 1) begin
        chk("rst_rvalid", 32'(bus.ext_rvalid), 32'd0);
        chk("rst_rdata",  bus.ext_rdata,       32'd0);
      end
      next_cycle();
    end

    // core store then load
    rst = 1'b0;
    ext_drive(1'b0, 1'b0, 32'h0, 32'h0);
    core_drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("core_st_we",    32'(bus.mem_we),     32'd1);
    chk("core_st_addr",  bus.mem_addr,        32'h10);
    chk("core_st_stall", 32'(bus.stall_core), 32'd0);
    next_cycle();
    core_drive(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("core_ld_data",  bus.core_rdata,      32'hDEADBEEF);
    chk("core_ld_we",    32'(bus.mem_we),     32'd0);
    chk("core_ld_stall", 32'(bus.stall_core), 32'd0);
    next_cycle();

    // ext read with core idle
    core_drive(1'b0, 1'b0, 32'h0, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("ext_rd_gnt",  32'(bus.ext_gnt), 32'd1);
    chk("ext_rd_addr", bus.mem_addr,     32'h10);
    next_cycle();
    ext_drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ext_rd_rvalid", 32'(bus.ext_rvalid), 32'd1);
    chk("ext_rd_rdata",  bus.ext_rdata,       32'hDEADBEEF);
    chk("ext_rd_gnt0",   32'(bus.ext_gnt),    32'd0);
    next_cycle();

    // starvation: forced grants in cycles 4 and 9
    core_drive(1'b1, 1'b0, 32'h0, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("starve_gnt_c%0d", c),    32'(bus.ext_gnt),    32'((c == 4) || (c == 9)));
      chk($sformatf("starve_stall_c%0d", c),  32'(bus.stall_core), 32'((c == 4) || (c == 9)));
      chk($sformatf("starve_rvalid_c%0d", c), 32'(bus.ext_rvalid), 32'(c == 5));
      if (c == 5) chk("starve_rdata", bus.ext_rdata, 32'hDEADBEEF);
      next_cycle();
    end

    // ext store then core load of the same word
    core_drive(1'b0, 1'b0, 32'h0, 32'h0);
    ext_drive(1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    chk("ext_wr_gnt", 32'(bus.ext_gnt), 32'd1);
    chk("ext_wr_we",  32'(bus.mem_we),  32'd1);
    next_cycle();
    ext_drive(1'b0, 1'b0, 32'h0, 32'h0);
    core_drive(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("ext_wr_core_ld", bus.core_rdata,      32'h12345678);
    chk("ext_wr_rvalid",  32'(bus.ext_rvalid), 32'd0);
    next_cycle();

    // reset the cycle after an ext read grant
    core_drive(1'b0, 1'b0, 32'h0, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("rmid_gnt", 32'(bus.ext_gnt), 32'd1);
    next_cycle();
    rst = 1'b1;
    core_drive(1'b1, 1'b1, 32'h30, 32'h0);
    @(negedge clk);
    chk("rmid_gnt_rst",   32'(bus.ext_gnt),    32'd0);
    chk("rmid_stall_rst", 32'(bus.stall_core), 32'd0);
    chk("rmid_we_rst",    32'(bus.mem_we),     32'd0);
    next_cycle();
    rst = 1'b0;
    core_drive(1'b1, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("rmid_rvalid", 32'(bus.ext_rvalid), 32'd0);
      chk($sformatf("rmid_gnt_c%0d", c), 32'(bus.ext_gnt), 32'(c == 4));
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline's MEM stage (core port) and an external requester such as a program loader or debug port (ext port). Core has priority; an anti-starvation counter forces an ext grant after a bounded wait and stalls the core for that cycle. Sits between the MEM stage and the data memory, driving the memory's write enable, address, write data and funct3, and returning its read data to either requester.

## Interface

- DATA_WIDTH, 32, data and address width
- STARVE_LIMIT, 4, maximum consecutive cycles ext may wait while core requests; legal range 1..15

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  MEM stage has a load or store this cycle
- core_we  in  1  core store
- core_addr  in  DATA_WIDTH  core byte address (ALU result)
- core_wd  in  DATA_WIDTH  core store data
- core_funct3  in  3  core access size/sign
- core_rdata  out  DATA_WIDTH  load data to writeback; valid when core_req && !stall_core
- stall_core  out  1  hold IF/ID/EX/MEM, bubble WB this cycle
- ext_req  in  1  ext access request; held until ext_gnt
- ext_we  in  1  ext store
- ext_addr  in  DATA_WIDTH  ext byte address
- ext_wd  in  DATA_WIDTH  ext store data
- ext_funct3  in  3  ext access size/sign
- ext_gnt  out  1  ext access performed this cycle
- ext_rvalid  out  1  registered ext load data valid
- ext_rdata  out  DATA_WIDTH  registered ext load data
- mem_we, mem_addr, mem_wd, mem_funct3  out  1/DATA_WIDTH/DATA_WIDTH/3  to data memory
- mem_rd  in  DATA_WIDTH  combinational read data from memory

## Operation

- State: wait_cnt (4 bits, saturating at STARVE_LIMIT), ext_rvalid, ext_rdata.
- Grant, combinational: ext_gnt = !rst && ext_req && (!core_req || wait_cnt == STARVE_LIMIT). Core owns the port whenever ext_gnt = 0.
- Mux: ext_gnt selects ext_* onto mem_*; otherwise core_*. mem_we = ext_gnt ? ext_we : (core_req && core_we); forced 0 during rst.
- stall_core = core_req && ext_gnt.
- core_rdata = mem_rd (pass-through; memory read is combinational).
- wait_cnt: cleared when rst, ext_gnt, or !ext_req; else incremented if core_req and below STARVE_LIMIT; else held.
- Response: on a cycle with ext_gnt && !ext_we, next cycle ext_rvalid = 1 and ext_rdata = mem_rd captured that edge; any other cycle ext_rvalid = 0, ext_rdata holds.
- A forced grant clears wait_cnt, so two consecutive forced grants are impossible; core always progresses at least STARVE_LIMIT cycles between forced grants.
- Ext handshake: ext_* must stay stable while ext_req && !ext_gnt; ext_req may stay high after grant to request the next access.

## Timing

- Reset values: wait_cnt 0, ext_rvalid 0, ext_rdata 0; while rst high ext_gnt 0, stall_core 0, mem_we 0.
- Core latency 0 cycles (same-cycle data); store writes at the edge closing the grant cycle.
- Ext grant latency: 0 cycles if core idle; otherwise at most STARVE_LIMIT cycles while core requests continuously.
- Ext read latency: ext_rvalid exactly 1 cycle after ext_gnt.
- Back-to-back ext accesses with core idle: ext_gnt every cycle, ext_rvalid pipelined every cycle.
- Reset asserted the cycle after a read grant: ext_rvalid 0 next cycle; response is dropped.
- ext_req deasserted while waiting: wait_cnt 0 next cycle.

## Test plan

- Reset: rst high 2 cycles with core_req=ext_req=1 -> ext_gnt=0, stall_core=0, mem_we=0, ext_rvalid=0, ext_rdata=0.
- Core only: store word 0xDEADBEEF at 0x10, then load 0x10 -> mem_we=1 on store, core_rdata=0xDEADBEEF same cycle as load, stall_core=0.
- Ext only: ext read 0x10 with core idle -> ext_gnt same cycle, ext_rvalid=1 and ext_rdata=0xDEADBEEF next cycle.
- Starvation, STARVE_LIMIT=4: core_req held high, ext read from cycle 0 -> ext_gnt and stall_core high in cycle 4 only, ext_rvalid in cycle 5, core resumes cycle 5, next forced grant no earlier than cycle 9.
- Ext write then core load same address: ext store 0x12345678 to 0x20, core load 0x20 next cycle -> core_rdata=0x12345678, ext_rvalid stays 0.
- Reset mid-access: rst asserted the cycle after ext read grant -> ext_rvalid=0, wait_cnt=0, no spurious grant.
